// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared walk-state encoding and colour width for the sprite renderer
package sprite_pkg;

  localparam int RGB_W = 12;

  typedef enum logic [1:0] {
    WALK_DOWN  = 2'd0,
    WALK_RIGHT = 2'd1,
    WALK_UP    = 2'd2,
    WALK_LEFT  = 2'd3
  } walk_state_e;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running 0..MAX divider, TRIG_OUT high for the CLK spent at MAX
module tick_divider #(
  parameter int WIDTH = 24,
  parameter int MAX   = 14999999
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TRIG_OUT
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;

  always_comb begin
    at_max  = (count_q == MAX_V);
    count_d = count_q;
    if (ENABLE) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Held count while ENABLE is low, so no trigger can fire from a frozen divider.
  assign TRIG_OUT = ENABLE & at_max;

endmodule

// File: rtl/perimeter_sprite_gen.sv
// rtl/perimeter_sprite_gen.sv - timed sprite mover (perimeter walk / bounce) and pixel renderer; BG_INVERT_EN inverts background
module perimeter_sprite_gen
  import sprite_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20,
  parameter int STEP_PX  = 1,
  parameter int TICK_DIV = 14999999
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             MODE,
  input  logic [9:0]       ADDRESS_H,
  input  logic [8:0]       ADDRESS_V,
  output logic [RGB_W-1:0] COLOUR_OUT,
  output logic [9:0]       SPRITE_X,
  output logic [8:0]       SPRITE_Y,
  output logic             CORNER
);

  localparam int         DIV_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV + 1);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] STEP_X = 11'(STEP_PX);
  localparam logic [9:0]  STEP_Y = 10'(STEP_PX);
  localparam logic [10:0] SPR_W  = 11'(SPRITE_W);
  localparam logic [9:0]  SPR_H  = 10'(SPRITE_H);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);

  logic             tick;
  logic [RGB_W-1:0] colour_q, colour_d;
  logic [RGB_W-1:0] pix_q, pix_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  walk_state_e      state_q, state_d;
  logic             dx_neg_q, dx_neg_d;
  logic             dy_neg_q, dy_neg_d;
  logic             mode_q, mode_d;
  logic             corner_q, corner_d;

  logic [10:0] x_inc, x_dec, h_ext;
  logic [9:0]  y_inc, y_dec, v_ext;
  logic        x_high, x_low, y_high, y_low;
  logic        hit;
  logic [RGB_W-1:0] bg;

  tick_divider #(.WIDTH(DIV_W), .MAX(TICK_DIV)) u_tick_divider (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .TRIG_OUT (tick)
  );

  // One extra bit lets a step below zero show up as a set MSB before clamping.
  always_comb begin
    x_inc  = {1'b0, x_q} + STEP_X;
    x_dec  = {1'b0, x_q} - STEP_X;
    y_inc  = {1'b0, y_q} + STEP_Y;
    y_dec  = {1'b0, y_q} - STEP_Y;
    x_high = (x_inc >= X_MAX);
    x_low  = x_dec[10] || (x_dec == 11'd0);
    y_high = (y_inc >= Y_MAX);
    y_low  = y_dec[9] || (y_dec == 10'd0);
  end

  always_comb begin
    colour_d = colour_q;
    x_d      = x_q;
    y_d      = y_q;
    state_d  = state_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    mode_d   = mode_q;
    corner_d = 1'b0;
    if (tick) begin
      colour_d = colour_q + RGB_W'(1);
      if (MODE != mode_q) begin
        x_d      = '0;
        y_d      = '0;
        state_d  = WALK_DOWN;
        dx_neg_d = 1'b0;
        dy_neg_d = 1'b0;
        mode_d   = MODE;
      end else if (!mode_q) begin
        case (state_q)
          WALK_DOWN: begin
            y_d = y_high ? Y_MAX[8:0] : y_inc[8:0];
            if (y_high) begin state_d = WALK_RIGHT; corner_d = 1'b1; end
          end
          WALK_RIGHT: begin
            x_d = x_high ? X_MAX[9:0] : x_inc[9:0];
            if (x_high) begin state_d = WALK_UP; corner_d = 1'b1; end
          end
          WALK_UP: begin
            y_d = y_low ? 9'd0 : y_dec[8:0];
            if (y_low) begin state_d = WALK_LEFT; corner_d = 1'b1; end
          end
          default: begin
            x_d = x_low ? 10'd0 : x_dec[9:0];
            if (x_low) begin state_d = WALK_DOWN; corner_d = 1'b1; end
          end
        endcase
      end else begin
        if (!dx_neg_q) begin
          x_d = x_high ? X_MAX[9:0] : x_inc[9:0];
          if (x_high) begin dx_neg_d = 1'b1; corner_d = 1'b1; end
        end else begin
          x_d = x_low ? 10'd0 : x_dec[9:0];
          if (x_low) begin dx_neg_d = 1'b0; corner_d = 1'b1; end
        end
        if (!dy_neg_q) begin
          y_d = y_high ? Y_MAX[8:0] : y_inc[8:0];
          if (y_high) begin dy_neg_d = 1'b1; corner_d = 1'b1; end
        end else begin
          y_d = y_low ? 9'd0 : y_dec[8:0];
          if (y_low) begin dy_neg_d = 1'b0; corner_d = 1'b1; end
        end
      end
    end
  end

  always_comb begin
    h_ext = {1'b0, ADDRESS_H};
    v_ext = {1'b0, ADDRESS_V};
    hit   = (h_ext >= {1'b0, x_q}) && (h_ext < ({1'b0, x_q} + SPR_W)) &&
            (v_ext >= {1'b0, y_q}) && (v_ext < ({1'b0, y_q} + SPR_H));
`ifdef BG_INVERT_EN
    bg    = ~colour_q;
`else
    bg    = '0;
`endif
    pix_d = ((h_ext >= H_ACT) || (v_ext >= V_ACT)) ? '0 : (hit ? colour_q : bg);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      colour_q <= '0;
      pix_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      state_q  <= WALK_DOWN;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      mode_q   <= 1'b0;
      corner_q <= 1'b0;
    end else begin
      colour_q <= colour_d;
      pix_q    <= pix_d;
      x_q      <= x_d;
      y_q      <= y_d;
      state_q  <= state_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      mode_q   <= mode_d;
      corner_q <= corner_d;
    end
  end

  assign COLOUR_OUT = pix_q;
  assign SPRITE_X   = x_q;
  assign SPRITE_Y   = y_q;
  assign CORNER     = corner_q;

endmodule

// File: tb/tb_perimeter_sprite_gen.sv
// tb/tb_perimeter_sprite_gen.sv - randomized bench for perimeter_sprite_gen against a behavioural model (BG_INVERT_EN aware)
module tb_perimeter_sprite_gen;

  localparam int HA = 64, VA = 48, SW = 8, SH = 8, STEP = 4, TDIV = 3;
  localparam int XMAX = HA - SW, YMAX = VA - SH;

  logic        clk, rst, enable, mode;
  logic [9:0]  addr_h;
  logic [8:0]  addr_v;
  logic [11:0] colour_out;
  logic [9:0]  sprite_x;
  logic [8:0]  sprite_y;
  logic        corner;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_x, m_y, m_dx, m_dy, m_walk, m_mode, m_colour, m_div, m_ticks;
  int m_corner;
  logic [11:0] exp_pix;

  perimeter_sprite_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SPRITE_W(SW), .SPRITE_H(SH),
    .STEP_PX(STEP), .TICK_DIV(TDIV)
  ) dut (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .MODE(mode),
    .ADDRESS_H(addr_h), .ADDRESS_V(addr_v),
    .COLOUR_OUT(colour_out), .SPRITE_X(sprite_x), .SPRITE_Y(sprite_y), .CORNER(corner)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [11:0] model_bg();
    logic [11:0] c;
    c = 12'(m_colour);
`ifdef BG_INVERT_EN
    return ~c;
`else
    return 12'h000;
`endif
  endfunction

  function automatic logic [11:0] model_pix(input int h, input int v);
    if (h >= HA || v >= VA) return 12'h000;
    if (h >= m_x && h < m_x + SW && v >= m_y && v < m_y + SH) return 12'(m_colour);
    return model_bg();
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_walk = 0; m_mode = 0;
    m_colour = 0; m_div = 0; m_ticks = 0; m_corner = 0;
  endtask

  task automatic model_tick();
    int vx, vy, nx, ny;
    m_colour = (m_colour + 1) % 4096;
    if ((mode ? 1 : 0) != m_mode) begin
      m_x = 0; m_y = 0; m_walk = 0; m_dx = 1; m_dy = 1; m_mode = mode ? 1 : 0;
    end else if (m_mode == 0) begin
      vx = (m_walk == 1) ? 1 : ((m_walk == 3) ? -1 : 0);
      vy = (m_walk == 0) ? 1 : ((m_walk == 2) ? -1 : 0);
      nx = clamp(m_x + vx * STEP, XMAX);
      ny = clamp(m_y + vy * STEP, YMAX);
      if ((vx > 0 && nx == XMAX) || (vx < 0 && nx == 0) ||
          (vy > 0 && ny == YMAX) || (vy < 0 && ny == 0)) begin
        m_corner = 1;
        m_walk = (m_walk + 1) % 4;
      end
      m_x = nx; m_y = ny;
    end else begin
      nx = m_x + m_dx * STEP;
      ny = m_y + m_dy * STEP;
      if (nx <= 0 || nx >= XMAX) begin nx = clamp(nx, XMAX); m_dx = -m_dx; m_corner = 1; end
      if (ny <= 0 || ny >= YMAX) begin ny = clamp(ny, YMAX); m_dy = -m_dy; m_corner = 1; end
      m_x = nx; m_y = ny;
    end
  endtask

  // Advance model and DUT by one clock; leaves time at 1 unit past the edge.
  task automatic clk_step();
    logic is_tick;
    exp_pix = model_pix(int'(addr_h), int'(addr_v));
    is_tick = enable && (m_div == TDIV);
    if (enable) m_div = (m_div == TDIV) ? 0 : m_div + 1;
    m_corner = 0;
    if (is_tick) begin
      model_tick();
      m_ticks++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addr();
    int h, v;
    if ($urandom_range(0, 1) == 1) begin
      h = m_x + int'($urandom_range(0, 11)) - 2;
      v = m_y + int'($urandom_range(0, 11)) - 2;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
    end else begin
      h = int'($urandom_range(0, 79));
      v = int'($urandom_range(0, 59));
    end
    addr_h = 10'(h);
    addr_v = 9'(v);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (6) begin rand_addr(); clk_step(); end
    addr_h = 10'(m_x); addr_v = 9'(m_y);
    clk_step();
    n_checks++;
    if (colour_out !== exp_pix) begin
      n_fail++; $display("FAIL reset_pre_colour got %h exp %h", colour_out, exp_pix);
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (sprite_x !== 10'd0) begin n_fail++; $display("FAIL reset_x got %0d exp 0", sprite_x); end
    if (sprite_y !== 9'd0) begin n_fail++; $display("FAIL reset_y got %0d exp 0", sprite_y); end
    if (colour_out !== 12'h000) begin n_fail++; $display("FAIL reset_colour got %h exp 000", colour_out); end
    if (corner !== 1'b0) begin n_fail++; $display("FAIL reset_corner got %b exp 0", corner); end
    model_reset();
    #2 rst = 1'b0;
    repeat (3) clk_step();
    n_checks++;
    if (sprite_y !== 9'd0) begin n_fail++; $display("FAIL first_tick_early y got %0d exp 0", sprite_y); end
    clk_step();
    n_checks++;
    if (sprite_y !== 9'(STEP)) begin n_fail++; $display("FAIL first_tick y got %0d exp %0d", sprite_y, STEP); end
  endtask

  task automatic test_perimeter();
    int corner_ticks[$];
    int cx[$], cy[$];
    int exp_t[4] = '{10, 24, 34, 48};
    int exp_x[4] = '{0, 56, 56, 0};
    int exp_y[4] = '{40, 40, 0, 0};
    apply_reset();
    mode = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 400 && m_ticks < 48; i++) begin
      rand_addr();
      clk_step();
      n_checks += 4;
      if (sprite_x !== m_x[9:0]) begin n_fail++; $display("FAIL perim_x got %0d exp %0d", sprite_x, m_x); end
      if (sprite_y !== m_y[8:0]) begin n_fail++; $display("FAIL perim_y got %0d exp %0d", sprite_y, m_y); end
      if (corner !== m_corner[0]) begin n_fail++; $display("FAIL perim_corner got %b exp %0d", corner, m_corner); end
      if (colour_out !== exp_pix) begin n_fail++; $display("FAIL perim_colour got %h exp %h", colour_out, exp_pix); end
      if (corner === 1'b1) begin
        corner_ticks.push_back(m_ticks);
        cx.push_back(int'(sprite_x));
        cy.push_back(int'(sprite_y));
      end
    end
    n_checks++;
    if (corner_ticks.size() != 4) begin
      n_fail++; $display("FAIL perim_corner_count got %0d exp 4", corner_ticks.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks += 3;
        if (corner_ticks[k] != exp_t[k]) begin n_fail++; $display("FAIL perim_corner_tick got %0d exp %0d", corner_ticks[k], exp_t[k]); end
        if (cx[k] != exp_x[k]) begin n_fail++; $display("FAIL perim_corner_x got %0d exp %0d", cx[k], exp_x[k]); end
        if (cy[k] != exp_y[k]) begin n_fail++; $display("FAIL perim_corner_y got %0d exp %0d", cy[k], exp_y[k]); end
      end
    end
  endtask

  task automatic test_bounce();
    int t0, n_corner, last_corner;
    mode = 1'b1;
    t0 = m_ticks;
    for (int i = 0; i < 8 && m_ticks == t0; i++) begin
      clk_step();
      n_checks++;
      if (corner !== 1'b0) begin n_fail++; $display("FAIL mode_switch_corner got %b exp 0", corner); end
    end
    n_checks += 2;
    if (sprite_x !== 10'd0 || sprite_y !== 9'd0) begin
      n_fail++; $display("FAIL mode_switch_pos got (%0d,%0d) exp (0,0)", sprite_x, sprite_y);
    end
    if (m_ticks == t0) begin n_fail++; $display("FAIL mode_switch_timeout no tick seen"); end
    t0 = m_ticks; n_corner = 0; last_corner = -1;
    for (int i = 0; i < 100 && m_ticks < t0 + 10; i++) begin
      clk_step();
      if (corner === 1'b1) begin n_corner++; last_corner = m_ticks - t0; end
    end
    n_checks += 3;
    if (sprite_x !== 10'd40 || sprite_y !== 9'd40) begin
      n_fail++; $display("FAIL bounce10_pos got (%0d,%0d) exp (40,40)", sprite_x, sprite_y);
    end
    if (n_corner != 1) begin n_fail++; $display("FAIL bounce10_corner_count got %0d exp 1", n_corner); end
    if (last_corner != 10) begin n_fail++; $display("FAIL bounce10_corner_tick got %0d exp 10", last_corner); end
    t0 = m_ticks;
    for (int i = 0; i < 8 && m_ticks == t0; i++) clk_step();
    n_checks++;
    if (sprite_x !== 10'd44 || sprite_y !== 9'd36) begin
      n_fail++; $display("FAIL bounce11_pos got (%0d,%0d) exp (44,36)", sprite_x, sprite_y);
    end
    for (int i = 0; i < 240; i++) begin
      rand_addr();
      clk_step();
      n_checks += 4;
      if (sprite_x !== m_x[9:0]) begin n_fail++; $display("FAIL bounce_x got %0d exp %0d", sprite_x, m_x); end
      if (sprite_y !== m_y[8:0]) begin n_fail++; $display("FAIL bounce_y got %0d exp %0d", sprite_y, m_y); end
      if (corner !== m_corner[0]) begin n_fail++; $display("FAIL bounce_corner got %b exp %0d", corner, m_corner); end
      if (colour_out !== exp_pix) begin n_fail++; $display("FAIL bounce_colour got %h exp %h", colour_out, exp_pix); end
    end
  endtask

  task automatic test_render();
    int hs[6], vs[6];
    logic [11:0] want[6];
    enable = 1'b0;
    hs = '{m_x, m_x + SW - 1, m_x + SW, m_x, 70, m_x};
    vs = '{m_y, m_y + SH - 1, m_y, m_y + SH, m_y, 50};
    want[0] = 12'(m_colour);
    want[1] = 12'(m_colour);
    want[2] = (m_x + SW < HA) ? model_bg() : 12'h000;
    want[3] = (m_y + SH < VA) ? model_bg() : 12'h000;
    want[4] = 12'h000;
    want[5] = 12'h000;
    for (int k = 0; k < 6; k++) begin
      addr_h = 10'(hs[k]);
      addr_v = 9'(vs[k]);
      clk_step();
      n_checks++;
      if (colour_out !== want[k]) begin
        n_fail++; $display("FAIL render_%0d at (%0d,%0d) got %h exp %h", k, hs[k], vs[k], colour_out, want[k]);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_enable();
    int sx, sy, sc, held, waited;
    enable = 1'b1;
    repeat ($urandom_range(1, 3)) clk_step();
    enable = 1'b0;
    sx = m_x; sy = m_y; sc = m_colour; held = m_div;
    for (int i = 0; i < 100; i++) begin
      rand_addr();
      clk_step();
      n_checks += 2;
      if (sprite_x !== sx[9:0] || sprite_y !== sy[8:0]) begin
        n_fail++; $display("FAIL hold_pos got (%0d,%0d) exp (%0d,%0d)", sprite_x, sprite_y, sx, sy);
      end
      if (corner !== 1'b0) begin n_fail++; $display("FAIL hold_corner got %b exp 0", corner); end
    end
    addr_h = 10'(sx); addr_v = 9'(sy);
    clk_step();
    n_checks++;
    if (colour_out !== 12'(sc)) begin n_fail++; $display("FAIL hold_colour got %h exp %h", colour_out, 12'(sc)); end
    enable = 1'b1;
    waited = 0;
    for (int i = 0; i < 10 && sprite_x === sx[9:0] && sprite_y === sy[8:0]; i++) begin
      clk_step();
      waited++;
    end
    n_checks++;
    if (waited != TDIV - held + 1) begin
      n_fail++; $display("FAIL resume_latency got %0d exp %0d", waited, TDIV - held + 1);
    end
  endtask

  task automatic test_mode_toggle();
    int t0;
    mode = 1'b0;
    t0 = m_ticks;
    for (int i = 0; i < 200 && m_ticks < t0 + 16; i++) begin
      rand_addr();
      clk_step();
      n_checks += 3;
      if (sprite_x !== m_x[9:0]) begin n_fail++; $display("FAIL walk_x got %0d exp %0d", sprite_x, m_x); end
      if (sprite_y !== m_y[8:0]) begin n_fail++; $display("FAIL walk_y got %0d exp %0d", sprite_y, m_y); end
      if (corner !== m_corner[0]) begin n_fail++; $display("FAIL walk_corner got %b exp %0d", corner, m_corner); end
    end
    n_checks++;
    if (sprite_x === 10'd0 && sprite_y === 9'd0) begin
      n_fail++; $display("FAIL walk_mid got (0,0) exp a position away from origin");
    end
    mode = 1'b1;
    t0 = m_ticks;
    for (int i = 0; i < 8 && m_ticks == t0; i++) begin
      clk_step();
      n_checks++;
      if (corner !== 1'b0) begin n_fail++; $display("FAIL toggle_corner got %b exp 0", corner); end
    end
    n_checks++;
    if (sprite_x !== 10'd0 || sprite_y !== 9'd0) begin
      n_fail++; $display("FAIL toggle_pos got (%0d,%0d) exp (0,0)", sprite_x, sprite_y);
    end
    enable = 1'b0;
    addr_h = 10'd40; addr_v = 9'd30;
    clk_step();
    n_checks++;
    if (colour_out !== model_bg()) begin
      n_fail++; $display("FAIL background got %h exp %h", colour_out, model_bg());
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_addr();
      clk_step();
      n_checks += 2;
      if (sprite_x !== m_x[9:0] || sprite_y !== m_y[8:0]) begin
        n_fail++; $display("FAIL toggle_after_pos got (%0d,%0d) exp (%0d,%0d)", sprite_x, sprite_y, m_x, m_y);
      end
      if (colour_out !== exp_pix) begin n_fail++; $display("FAIL toggle_after_colour got %h exp %h", colour_out, exp_pix); end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; enable = 1'b1; mode = 1'b0;
    addr_h = '0; addr_v = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_perimeter();
    test_bounce();
    test_render();
    test_enable();
    test_mode_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
